// File: rtl/score_bcd_converter.sv
// score_bcd_converter
//
// Purpose:
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   It processes one input bit per clock and feeds the 4-digit seven-segment
//   driver. digit3 is the leftmost display digit and digit0 is the rightmost.
//   The result registers hold the last completed value, so the display never
//   shows a half-converted number. Values above 10^DIGITS-1 are shown as all
//   4'hF, which the display renders as dashes.
//
// Ports:
//   clk       in   1      system clock
//   reset     in   1      asynchronous, active-high reset
//   start     in   1      conversion request, sampled only while idle
//   bin       in   WIDTH  unsigned value, captured when start is accepted
//   busy      out  1      high while a conversion is in progress
//   done      out  1      one-cycle pulse when the digit outputs update
//   overflow  out  1      last captured value exceeded 10^DIGITS-1
//   digit0    out  4      BCD units
//   digit1    out  4      BCD tens
//   digit2    out  4      BCD hundreds
//   digit3    out  4      BCD thousands
module score_bcd_converter #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       digit0,
    output logic [3:0]       digit1,
    output logic [3:0]       digit2,
    output logic [3:0]       digit3
);

    localparam int               MAXVAL   = (10 ** DIGITS) - 1;
    localparam logic [WIDTH-1:0] MAXVAL_W = WIDTH'(MAXVAL);
    localparam int               BCD_W    = 4 * DIGITS;
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcdAdj_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;
    logic               overflow_q;
    logic [3:0]         digit0_q;
    logic [3:0]         digit1_q;
    logic [3:0]         digit2_q;
    logic [3:0]         digit3_q;

    // Add-3 correction, applied to every nibble in parallel from the
    // pre-shift accumulator value. After the following left shift, each
    // nibble then carries correctly into the next decimal place.
    always_comb begin
        bcdAdj_d = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcdAdj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Control FSM, datapath and registered outputs.
    // The digit and overflow registers are written only in LOAD, so the
    // display keeps its previous value for the whole conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digit0_q   <= 4'd0;
            digit1_q   <= 4'd0;
            digit2_q   <= 4'd0;
            digit3_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shreg_q <= bin;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= (bin > MAXVAL_W);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    // Shift {bcd, shreg} left by one. Any carry out of the top
                    // nibble is dropped; an out-of-range input is already
                    // flagged by ovf_q.
                    bcd_q   <= {bcdAdj_d[BCD_W-2:0], shreg_q[WIDTH-1]};
                    shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    overflow_q <= ovf_q;
                    digit0_q   <= ovf_q ? 4'hF : bcd_q[3:0];
                    digit1_q   <= ovf_q ? 4'hF : bcd_q[7:4];
                    digit2_q   <= ovf_q ? 4'hF : bcd_q[11:8];
                    digit3_q   <= ovf_q ? 4'hF : bcd_q[15:12];
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign digit0   = digit0_q;
    assign digit1   = digit1_q;
    assign digit2   = digit2_q;
    assign digit3   = digit3_q;

endmodule
